// File: rtl/av_mode_regs.sv
// av_mode_regs: Avalon-MM slave register bank with a per-register access mode
// (RW, RO, W1C sticky, self-clearing PULSE) and a pipelined read path.
// Optional feature: define AV_MODE_REGS_IRQ_EN to add irq_o, a registered OR
// of every bit held in the W1C registers.
module av_mode_regs #(
  parameter int DW         = 32,
  parameter int AW         = 16,
  parameter int REGS_NUM   = 16,
  parameter logic [REGS_NUM-1:0][DW-1:0] REGS_INIT = '0,
  parameter logic [REGS_NUM-1:0][1:0]    REGS_MODE = '0,
  parameter int RD_LATENCY = 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [AW-1:0]          avms_address,
  input  logic [DW/8-1:0]        avms_byteenable,
  input  logic                   avms_read,
  input  logic                   avms_write,
  input  logic [DW-1:0]          avms_writedata,
  output logic [DW-1:0]          avms_readdata,
  output logic                   avms_readdatavalid,
  output logic [1:0]             avms_response,
  output logic [REGS_NUM-1:0]    word_valid_wr_o,
  output logic [REGS_NUM*DW-1:0] mst_word_o,
  input  logic [REGS_NUM*DW-1:0] slv_word_i
`ifdef AV_MODE_REGS_IRQ_EN
  ,
  output logic                   irq_o
`endif
);

  localparam logic [1:0] MODE_RW    = 2'd0;
  localparam logic [1:0] MODE_RO    = 2'd1;
  localparam logic [1:0] MODE_W1C   = 2'd2;
  localparam logic [1:0] MODE_PULSE = 2'd3;

  localparam logic [AW:0] REGS_NUM_W = (AW+1)'(REGS_NUM);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  logic [DW-1:0]                lane_mask;
  logic [DW-1:0]                wr_masked;
  logic                         addr_in_range;
  logic                         wr_acc;
  logic                         rd_acc;
  logic [REGS_NUM-1:0]          wr_hit;

  logic [REGS_NUM-1:0][DW-1:0]  reg_q, reg_d;
  logic [REGS_NUM-1:0]          wr_pulse_q, wr_pulse_d;

  logic [DW-1:0]                rd_data_d;
  logic [1:0]                   rd_resp_d;
  logic [RD_LATENCY-1:0]        rd_vld_q;
  logic [DW-1:0]                rd_data_q [RD_LATENCY];
  logic [1:0]                   rd_resp_q [RD_LATENCY];

  // Status bits of RW and PULSE registers are never consumed.
  logic                         unused_slv;
  assign unused_slv = ^slv_word_i;

  assign addr_in_range = {1'b0, avms_address} < REGS_NUM_W;
  assign wr_acc        = avms_write & addr_in_range;
  // A write in the same cycle wins; the read is dropped without a response.
  assign rd_acc        = avms_read & ~avms_write;
  assign wr_masked     = avms_writedata & lane_mask;

  // Expand byte enables into a bit mask and decode which register is written.
  always_comb begin
    lane_mask = '0;
    wr_hit    = '0;
    for (int b = 0; b < DW/8; b++) begin
      lane_mask[b*8 +: 8] = {8{avms_byteenable[b]}};
    end
    for (int i = 0; i < REGS_NUM; i++) begin
      wr_hit[i] = wr_acc && (avms_address == AW'(i));
    end
  end

  // Next register contents and write pulses according to each register's mode.
  always_comb begin
    reg_d      = reg_q;
    wr_pulse_d = '0;
    for (int i = 0; i < REGS_NUM; i++) begin
      case (REGS_MODE[i])
        MODE_RW: begin
          if (wr_hit[i]) begin
            reg_d[i]      = (reg_q[i] & ~lane_mask) | wr_masked;
            wr_pulse_d[i] = 1'b1;
          end
        end
        MODE_RO: begin
          reg_d[i] = '0;
        end
        MODE_W1C: begin
          reg_d[i]      = (reg_q[i] & ~(wr_hit[i] ? wr_masked : '0))
                          | slv_word_i[i*DW +: DW];
          wr_pulse_d[i] = wr_hit[i];
        end
        MODE_PULSE: begin
          reg_d[i]      = wr_hit[i] ? wr_masked : '0;
          wr_pulse_d[i] = wr_hit[i];
        end
        default: begin
          reg_d[i] = reg_q[i];
        end
      endcase
    end
  end

  // Register storage and write pulses; RW/W1C come out of reset at REGS_INIT.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < REGS_NUM; i++) begin
        if (REGS_MODE[i] == MODE_RW || REGS_MODE[i] == MODE_W1C) begin
          reg_q[i] <= REGS_INIT[i];
        end else begin
          reg_q[i] <= '0;
        end
      end
      wr_pulse_q <= '0;
    end else begin
      reg_q      <= reg_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  // Read data selected at the accept edge; out-of-range returns 0 with SLVERR.
  always_comb begin
    rd_data_d = '0;
    rd_resp_d = RESP_OKAY;
    if (rd_acc) begin
      if (!addr_in_range) begin
        rd_resp_d = RESP_SLVERR;
      end else begin
        for (int i = 0; i < REGS_NUM; i++) begin
          if (avms_address == AW'(i)) begin
            case (REGS_MODE[i])
              MODE_RO:    rd_data_d = slv_word_i[i*DW +: DW];
              MODE_PULSE: rd_data_d = '0;
              default:    rd_data_d = reg_q[i];
            endcase
          end
        end
      end
    end
  end

  // Read response pipeline; idle slots carry zero data and OKAY.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_vld_q <= '0;
      for (int s = 0; s < RD_LATENCY; s++) begin
        rd_data_q[s] <= '0;
        rd_resp_q[s] <= RESP_OKAY;
      end
    end else begin
      rd_vld_q[0]  <= rd_acc;
      rd_data_q[0] <= rd_data_d;
      rd_resp_q[0] <= rd_resp_d;
      for (int s = 1; s < RD_LATENCY; s++) begin
        rd_vld_q[s]  <= rd_vld_q[s-1];
        rd_data_q[s] <= rd_data_q[s-1];
        rd_resp_q[s] <= rd_resp_q[s-1];
      end
    end
  end

  assign avms_readdatavalid = rd_vld_q[RD_LATENCY-1];
  assign avms_readdata      = rd_data_q[RD_LATENCY-1];
  assign avms_response      = rd_resp_q[RD_LATENCY-1];
  assign word_valid_wr_o    = wr_pulse_q;

  // Flatten register contents toward the core.
  always_comb begin
    mst_word_o = '0;
    for (int i = 0; i < REGS_NUM; i++) begin
      mst_word_o[i*DW +: DW] = reg_q[i];
    end
  end

`ifdef AV_MODE_REGS_IRQ_EN
  logic irq_q, irq_d;

  // Interrupt request whenever any W1C register holds a set bit.
  always_comb begin
    irq_d = 1'b0;
    for (int i = 0; i < REGS_NUM; i++) begin
      if (REGS_MODE[i] == MODE_W1C) begin
        irq_d = irq_d | (|reg_q[i]);
      end
    end
  end

  // Registered interrupt output.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_av_mode_regs.sv
// tb_av_mode_regs: randomized and directed stimulus for av_mode_regs, checked
// against a behavioural register-bank model with a timed response queue.
module tb_av_mode_regs;

  localparam int DW   = 32;
  localparam int AW   = 16;
  localparam int NREG = 16;
  localparam int LAT  = 3;

  localparam logic [1:0] M_RW    = 2'd0;
  localparam logic [1:0] M_RO    = 2'd1;
  localparam logic [1:0] M_W1C   = 2'd2;
  localparam logic [1:0] M_PULSE = 2'd3;

  // Regs 15..8 RW, 7 RO, 6 PULSE, 5 W1C, 4 RO, 3 PULSE, 2 W1C, 1 RW, 0 RW.
  localparam logic [NREG-1:0][1:0] MODES =
    {16'h0000, M_RO, M_PULSE, M_W1C, M_RO, M_PULSE, M_W1C, M_RW, M_RW};

  function automatic logic [NREG-1:0][31:0] buildInit();
    logic [NREG-1:0][31:0] v;
    for (int i = 0; i < NREG; i++) v[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
    v[0] = 32'hdaaddabb;
    v[1] = 32'h91838491;
    v[2] = 32'h0;
    v[5] = 32'h0000_0300;
    return v;
  endfunction

  localparam logic [NREG-1:0][31:0] INIT = buildInit();

  typedef struct {
    int          due;
    logic [31:0] data;
    logic [1:0]  resp;
  } rspT;

  logic                  clk = 1'b0;
  logic                  resetIn;
  logic [AW-1:0]         avmsAddress;
  logic [3:0]            avmsByteenable;
  logic                  avmsRead;
  logic                  avmsWrite;
  logic [31:0]           avmsWritedata;
  logic [31:0]           avmsReaddata;
  logic                  avmsReaddatavalid;
  logic [1:0]            avmsResponse;
  logic [NREG-1:0]       wordValidWr;
  logic [NREG-1:0][31:0] mstWord;
  logic [NREG-1:0][31:0] slvWord;
`ifdef AV_MODE_REGS_IRQ_EN
  logic                  irq;
`endif

  logic [31:0] modelReg   [NREG];
  logic [31:0] modelPulse [NREG];
  rspT         expQ [$];
  int          cycle;
  int          errors;
  int          checks;

  logic        rRd, rWr;
  logic [15:0] rAddr;
  logic [3:0]  rBe;
  logic [31:0] rWd;

  av_mode_regs #(
    .DW(DW), .AW(AW), .REGS_NUM(NREG),
    .REGS_INIT(INIT), .REGS_MODE(MODES), .RD_LATENCY(LAT)
  ) dut (
    .clk_i              (clk),
    .reset_i            (resetIn),
    .avms_address       (avmsAddress),
    .avms_byteenable    (avmsByteenable),
    .avms_read          (avmsRead),
    .avms_write         (avmsWrite),
    .avms_writedata     (avmsWritedata),
    .avms_readdata      (avmsReaddata),
    .avms_readdatavalid (avmsReaddatavalid),
    .avms_response      (avmsResponse),
    .word_valid_wr_o    (wordValidWr),
    .mst_word_o         (mstWord),
    .slv_word_i         (slvWord)
`ifdef AV_MODE_REGS_IRQ_EN
    ,
    .irq_o              (irq)
`endif
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < NREG; i++) begin
      modelReg[i]   = (MODES[i] == M_RW || MODES[i] == M_W1C) ? INIT[i] : 32'h0;
      modelPulse[i] = 32'h0;
    end
    expQ.delete();
  endtask

  task automatic checkCycle(input logic [15:0] expPulse, input logic expIrq);
    rspT r;
    if (expQ.size() > 0 && expQ[0].due == cycle) begin
      r = expQ.pop_front();
      checkOutput("rdvalid", {31'b0, avmsReaddatavalid}, 32'h1);
      checkOutput("rddata", avmsReaddata, r.data);
      checkOutput("rdresp", {30'b0, avmsResponse}, {30'b0, r.resp});
    end else begin
      checkOutput("rdvalid_idle", {31'b0, avmsReaddatavalid}, 32'h0);
      checkOutput("rddata_idle", avmsReaddata, 32'h0);
      checkOutput("rdresp_idle", {30'b0, avmsResponse}, 32'h0);
    end
    checkOutput("wr_pulse", {16'b0, wordValidWr}, {16'b0, expPulse});
    for (int i = 0; i < NREG; i++) begin
      if (MODES[i] != M_RO) begin
        checkOutput($sformatf("mst%0d", i), mstWord[i],
                    (MODES[i] == M_PULSE) ? modelPulse[i] : modelReg[i]);
      end
    end
`ifdef AV_MODE_REGS_IRQ_EN
    checkOutput("irq", {31'b0, irq}, {31'b0, expIrq});
`else
    if (expIrq === 1'bx) $display("[TB] irq expectation undefined");
`endif
  endtask

  // One bus cycle: drive inputs, advance the model across the edge, check.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr,
                               input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] mask;
    logic [31:0] clr;
    logic [15:0] expPulse;
    logic        expIrq;
    logic        inRange;
    int          idx;
    rspT         r;
    avmsRead       = rd;
    avmsWrite      = wr;
    avmsAddress    = addr;
    avmsByteenable = be;
    avmsWritedata  = wd;
    for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{be[b]}};
    inRange = (addr < 16'(NREG));
    idx     = int'(addr);
    expIrq  = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (MODES[i] == M_W1C && modelReg[i] != 32'h0) expIrq = 1'b1;
    end
    if (rd && !wr) begin
      r.due = cycle + LAT;
      if (!inRange) begin
        r.data = 32'h0;
        r.resp = 2'b10;
      end else begin
        r.resp = 2'b00;
        case (MODES[idx])
          M_RO:    r.data = slvWord[idx];
          M_PULSE: r.data = 32'h0;
          default: r.data = modelReg[idx];
        endcase
      end
      expQ.push_back(r);
    end
    expPulse = '0;
    for (int i = 0; i < NREG; i++) begin
      modelPulse[i] = 32'h0;
      if (MODES[i] == M_W1C) begin
        clr = (wr && inRange && idx == i) ? (wd & mask) : 32'h0;
        modelReg[i] = (modelReg[i] & ~clr) | slvWord[i];
      end
    end
    if (wr && inRange) begin
      case (MODES[idx])
        M_RW: begin
          modelReg[idx] = (modelReg[idx] & ~mask) | (wd & mask);
          expPulse[idx] = 1'b1;
        end
        M_W1C:   expPulse[idx] = 1'b1;
        M_PULSE: begin
          modelPulse[idx] = wd & mask;
          expPulse[idx]   = 1'b1;
        end
        default: ;
      endcase
    end
    @(posedge clk);
    cycle++;
    #1;
    checkCycle(expPulse, expIrq);
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
  endtask

  task automatic doReset();
    avmsRead  = 1'b0;
    avmsWrite = 1'b0;
    slvWord   = '0;
    resetIn   = 1'b1;
    resetModel();
    #1;
    checkCycle(16'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkCycle(16'h0, 1'b0);
    resetIn = 1'b0;
  endtask

  initial begin
    errors         = 0;
    checks         = 0;
    cycle          = 0;
    resetIn        = 1'b0;
    avmsRead       = 1'b0;
    avmsWrite      = 1'b0;
    avmsAddress    = '0;
    avmsByteenable = '0;
    avmsWritedata  = '0;
    slvWord        = '0;
    #2;
    doReset();

    // Read every register out of reset.
    for (int a = 0; a < NREG; a++) applyStimulus(1'b1, 1'b0, 16'(a), 4'hF, 32'h0);
    idleCycles(LAT + 1);

    // Partial-lane write to an RW register.
    applyStimulus(1'b0, 1'b1, 16'd1, 4'h3, 32'h12342574);
    checkOutput("t2_mst1", mstWord[1], 32'h91832574);
    checkOutput("t2_pulse1", {31'b0, wordValidWr[1]}, 32'h1);
    applyStimulus(1'b1, 1'b0, 16'd1, 4'hF, 32'h0);
    checkOutput("t2_pulse1_off", {31'b0, wordValidWr[1]}, 32'h0);
    idleCycles(LAT);

    // W1C set, clear, and set-wins-over-clear.
    slvWord[2] = 32'h5;
    idleCycles(1);
    slvWord[2] = 32'h0;
    checkOutput("t3_set", mstWord[2], 32'h5);
    applyStimulus(1'b0, 1'b1, 16'd2, 4'hF, 32'h1);
    checkOutput("t3_clr", mstWord[2], 32'h4);
    slvWord[2] = 32'h1;
    applyStimulus(1'b0, 1'b1, 16'd2, 4'hF, 32'h1);
    slvWord[2] = 32'h0;
    checkOutput("t3_setwins", mstWord[2], 32'h5);
    applyStimulus(1'b0, 1'b1, 16'd2, 4'hF, 32'hF);
    checkOutput("t3_allclr", mstWord[2], 32'h0);
    idleCycles(2);

    // PULSE register and RO register behaviour.
    applyStimulus(1'b0, 1'b1, 16'd3, 4'h7, 32'h5678beaf);
    checkOutput("t4_pulse", mstWord[3], 32'h0078beaf);
    idleCycles(1);
    checkOutput("t4_pulse_off", mstWord[3], 32'h0);
    applyStimulus(1'b1, 1'b0, 16'd3, 4'hF, 32'h0);
    slvWord[4] = 32'hcafe0004;
    applyStimulus(1'b0, 1'b1, 16'd4, 4'hF, 32'hffffffff);
    checkOutput("t4_ro_nopulse", {16'b0, wordValidWr}, 32'h0);
    applyStimulus(1'b1, 1'b0, 16'd4, 4'hF, 32'h0);
    idleCycles(LAT);

    // Read and write together: write lands, read is dropped.
    applyStimulus(1'b1, 1'b1, 16'd0, 4'hF, 32'h0bad0000);
    applyStimulus(1'b1, 1'b0, 16'd0, 4'hF, 32'h0);
    idleCycles(LAT);

    // Back-to-back reads including the first out-of-range address.
    for (int a = 0; a <= NREG; a++) applyStimulus(1'b1, 1'b0, 16'(a), 4'hF, 32'h0);
    applyStimulus(1'b0, 1'b1, 16'(NREG), 4'hF, 32'hffffffff);
    idleCycles(LAT + 1);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NREG; i++) begin
        if (MODES[i] == M_W1C)
          slvWord[i] = ($urandom_range(0, 5) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
        else
          slvWord[i] = $urandom;
      end
      rRd   = ($urandom_range(0, 1) == 1);
      rWr   = ($urandom_range(0, 4) < 2);
      rAddr = ($urandom_range(0, 19) == 0) ? 16'hffff : 16'($urandom_range(0, NREG + 1));
      rBe   = 4'($urandom_range(0, 15));
      rWd   = $urandom;
      applyStimulus(rRd, rWr, rAddr, rBe, rWd);
    end
    slvWord = '0;
    idleCycles(LAT + 1);

    // Reset with two reads in flight, then confirm reset contents.
    applyStimulus(1'b1, 1'b0, 16'd0, 4'hF, 32'h0);
    applyStimulus(1'b1, 1'b0, 16'd1, 4'hF, 32'h0);
    doReset();
    idleCycles(LAT + 1);
    for (int a = 0; a < NREG; a++) applyStimulus(1'b1, 1'b0, 16'(a), 4'hF, 32'h0);
    idleCycles(LAT + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
